// File: rtl/bank_command_sequencer_if.sv
// Request, row-buffer-tracker and command signals of the bank command sequencer.
// master: upstream requester / tracker side; slave: the sequencer itself.
interface bank_command_sequencer_if;
  localparam int unsigned ROW_W = 16;
  localparam int unsigned COL_W = 10;

  logic             req_valid;
  logic             req_ready;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             req_we;
  logic             row_open;
  logic             row_hit;
  logic [ROW_W-1:0] requested_row;
  logic             row_activate;
  logic             row_precharge;
  logic             cmd_valid;
  logic [1:0]       cmd_type;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             done;

  modport master (
    output req_valid, req_row, req_col, req_we, row_open, row_hit,
    input  req_ready, requested_row, row_activate, row_precharge,
    input  cmd_valid, cmd_type, cmd_row, cmd_col, done
  );

  modport slave (
    input  req_valid, req_row, req_col, req_we, row_open, row_hit,
    output req_ready, requested_row, row_activate, row_precharge,
    output cmd_valid, cmd_type, cmd_row, cmd_col, done
  );
endinterface

// File: rtl/bank_command_sequencer.sv
// Single-bank DRAM command sequencer: turns one row/column request into the
// PRE / ACT / RD|WR command sequence, honouring tRP and tRCD.
// Optional macro BANK_SEQ_AUTO_PRECHARGE_EN selects a close-page policy
// (precharge after every access); undefined gives an open-page policy.
module bank_command_sequencer #(
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RCD = 3
) (
  input logic sys_clk,
  input logic sys_rst,
  bank_command_sequencer_if.slave bus
);
  localparam int unsigned ROW_W = 16;
  localparam int unsigned COL_W = 10;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_PRE = 2'd1;
  localparam logic [1:0] CMD_RD  = 2'd2;
  localparam logic [1:0] CMD_WR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, CHECK, PRECHARGE, WAIT_RP, ACTIVATE, WAIT_RCD, ACCESS
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [1:0]       kind;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             done;
    logic             act;
    logic             pre;
  } cmd_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             we_q;
  logic             ready_q;
  cmd_t             cmd_q;
`ifdef BANK_SEQ_AUTO_PRECHARGE_EN
  logic             closing;
`endif

  function automatic cmd_t cmd_pre();
    cmd_t c;
    c       = '0;
    c.valid = 1'b1;
    c.kind  = CMD_PRE;
    c.pre   = 1'b1;
    return c;
  endfunction

  function automatic cmd_t cmd_act(input logic [ROW_W-1:0] row);
    cmd_t c;
    c       = '0;
    c.valid = 1'b1;
    c.kind  = CMD_ACT;
    c.row   = row;
    c.act   = 1'b1;
    return c;
  endfunction

  function automatic cmd_t cmd_access(input logic we, input logic [COL_W-1:0] col);
    cmd_t c;
    c       = '0;
    c.valid = 1'b1;
    c.kind  = we ? CMD_WR : CMD_RD;
    c.col   = col;
    c.done  = 1'b1;
    return c;
  endfunction

  // Sequencer FSM; command outputs are registered on entry to the issuing state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      cmd_q   <= '0;
`ifdef BANK_SEQ_AUTO_PRECHARGE_EN
      closing <= 1'b0;
`endif
    end else begin
      cmd_q <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            row_q   <= bus.req_row;
            col_q   <= bus.req_col;
            we_q    <= bus.req_we;
            ready_q <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (bus.row_hit) begin
            cmd_q <= cmd_access(we_q, col_q);
            state <= ACCESS;
          end else if (bus.row_open) begin
            cmd_q <= cmd_pre();
            state <= PRECHARGE;
          end else begin
            cmd_q <= cmd_act(row_q);
            state <= ACTIVATE;
          end
        end
        PRECHARGE: begin
          cnt   <= CNT_W'(T_RP - 2);
          state <= WAIT_RP;
        end
        WAIT_RP: begin
          if (cnt == '0) begin
`ifdef BANK_SEQ_AUTO_PRECHARGE_EN
            if (closing) begin
              closing <= 1'b0;
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              cmd_q <= cmd_act(row_q);
              state <= ACTIVATE;
            end
`else
            cmd_q <= cmd_act(row_q);
            state <= ACTIVATE;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACTIVATE: begin
          cnt   <= CNT_W'(T_RCD - 2);
          state <= WAIT_RCD;
        end
        WAIT_RCD: begin
          if (cnt == '0) begin
            cmd_q <= cmd_access(we_q, col_q);
            state <= ACCESS;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACCESS: begin
`ifdef BANK_SEQ_AUTO_PRECHARGE_EN
          cmd_q   <= cmd_pre();
          closing <= 1'b1;
          state   <= PRECHARGE;
`else
          ready_q <= 1'b1;
          state   <= IDLE;
`endif
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.requested_row = row_q;
  assign bus.cmd_valid     = cmd_q.valid;
  assign bus.cmd_type      = cmd_q.kind;
  assign bus.cmd_row       = cmd_q.row;
  assign bus.cmd_col       = cmd_q.col;
  assign bus.done          = cmd_q.done;
  assign bus.row_activate  = cmd_q.act;
  assign bus.row_precharge = cmd_q.pre;
endmodule

// File: tb/tb_bank_command_sequencer.sv
// Scoreboard bench for bank_command_sequencer: a driver issues directed then
// random requests and predicts the command timeline; a monitor compares it.
module tb_bank_command_sequencer;
  localparam int unsigned T_RP   = 3;
  localparam int unsigned T_RCD  = 2;
  localparam int unsigned CYCLES = 3000;

  localparam logic [1:0] K_ACT = 2'd0;
  localparam logic [1:0] K_PRE = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;
  localparam logic [1:0] K_WR  = 2'd3;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  kind;
    logic [15:0] row;
    logic [9:0]  col;
  } exp_t;

  typedef struct {
    logic [15:0] row;
    logic [9:0]  col;
    logic        we;
    int unsigned rst_delay;
  } stim_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t  exp_q[$];
  stim_t dir_q[$];

  // Reference state: model's view of the open row, and first cycle ready is due.
  logic        m_open = 1'b0;
  logic [15:0] m_row  = '0;
  int unsigned ready_from = 0;
  logic        prev_rst = 1'b0;

  // Behavioural row-buffer tracker feeding the sequencer.
  logic        trk_open = 1'b0;
  logic [15:0] trk_row  = '0;

  bank_command_sequencer_if bus ();

  bank_command_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    if (bus.row_precharge === 1'b1) trk_open <= 1'b0;
    else if (bus.row_activate === 1'b1) begin
      trk_open <= 1'b1;
      trk_row  <= bus.requested_row;
    end
  end

  assign bus.row_open = trk_open;
  assign bus.row_hit  = trk_open && (trk_row == bus.requested_row);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] pack(input logic v, input logic [1:0] k, input logic [15:0] r,
                                       input logic [9:0] c, input logic d, input logic a,
                                       input logic p);
    return {v, k, r, c, d, a, p};
  endfunction

  function automatic void push(input int unsigned t, input logic [1:0] k,
                               input logic [15:0] r, input logic [9:0] c);
    exp_t e;
    e.cyc  = t;
    e.kind = k;
    e.row  = r;
    e.col  = c;
    exp_q.push_back(e);
  endfunction

  // Predict the command timeline of a request accepted in cycle a.
  function automatic void predict(input int unsigned a, input logic [15:0] r,
                                  input logic [9:0] c, input logic we);
    int unsigned t;
    t = a + 2;
    if (!(m_open && m_row == r)) begin
      if (m_open) begin
        push(t, K_PRE, '0, '0);
        t = t + T_RP;
      end
      push(t, K_ACT, r, '0);
      t = t + T_RCD;
    end
    push(t, we ? K_WR : K_RD, '0, c);
`ifdef BANK_SEQ_AUTO_PRECHARGE_EN
    push(t + 1, K_PRE, '0, '0);
    ready_from = t + 1 + T_RP;
`else
    ready_from = t + 1;
`endif
  endfunction

  // Monitor: compare every cycle's outputs against the scoreboard.
  always @(negedge sys_clk) begin
    exp_t e;
    logic [31:0] got;
    logic [31:0] want;
    logic        acc;
    got = pack(bus.cmd_valid, bus.cmd_type, bus.cmd_row, bus.cmd_col,
               bus.done, bus.row_activate, bus.row_precharge);
    if (prev_rst) chk("reset_requested_row", 32'(bus.requested_row), 32'd0);
    if (!sys_rst) chk("req_ready", 32'(bus.req_ready), 32'(cyc >= ready_from));
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_command", 32'd0, pack(1'b1, e.kind, e.row, e.col, 1'b0, 1'b0, 1'b0));
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e    = exp_q.pop_front();
      acc  = (e.kind == K_RD) || (e.kind == K_WR);
      want = pack(1'b1, e.kind, (e.kind == K_ACT) ? e.row : 16'h0, acc ? e.col : 10'h0,
                  acc, e.kind == K_ACT, e.kind == K_PRE);
      chk("command", got, want);
      if (e.kind == K_PRE) m_open = 1'b0;
      else if (e.kind == K_ACT) begin
        m_open = 1'b1;
        m_row  = e.row;
      end
    end else begin
      chk("no_command", got, 32'd0);
    end
    prev_rst = sys_rst;
  end

  // Driver: directed requests first, then random traffic with occasional resets.
  initial begin
    stim_t       s;
    stim_t       cur;
    logic        pending;
    int unsigned rst_at;
    int unsigned wait_cnt;

    s.row = 16'h0012; s.col = 10'h005; s.we = 1'b0; s.rst_delay = 0; dir_q.push_back(s);
    s.row = 16'h0012; s.col = 10'h3FF; s.we = 1'b1; s.rst_delay = 0; dir_q.push_back(s);
    s.row = 16'hBEEF; s.col = 10'h011; s.we = 1'b0; s.rst_delay = 0; dir_q.push_back(s);
    s.row = 16'h0777; s.col = 10'h022; s.we = 1'b1; s.rst_delay = 3; dir_q.push_back(s);
    s.row = 16'h0777; s.col = 10'h033; s.we = 1'b0; s.rst_delay = 0; dir_q.push_back(s);

    bus.req_valid = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_we    = 1'b0;
    pending  = 1'b0;
    rst_at   = 0;
    wait_cnt = 0;
    cur      = s;
    repeat (3) @(posedge sys_clk);
    #1;
    ready_from = cyc;
    sys_rst    = 1'b0;

    while (cyc < CYCLES + 60) begin
      if (cyc < CYCLES && !pending) begin
        if (dir_q.size() != 0) begin
          cur     = dir_q.pop_front();
          pending = 1'b1;
        end else if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 3))
            0:       cur.row = 16'h0012;
            1:       cur.row = 16'hBEEF;
            2:       cur.row = 16'h0777;
            default: cur.row = 16'($urandom);
          endcase
          cur.col       = 10'($urandom);
          cur.we        = 1'($urandom);
          cur.rst_delay = 0;
          pending       = 1'b1;
        end
        wait_cnt = 0;
      end
      bus.req_valid = pending;
      bus.req_row   = cur.row;
      bus.req_col   = cur.col;
      bus.req_we    = cur.we;

      @(negedge sys_clk);
      #1;
      if (bus.req_valid && bus.req_ready) begin
        predict(cyc, cur.row, cur.col, cur.we);
        if (cur.rst_delay != 0) rst_at = cyc + cur.rst_delay;
        pending = 1'b0;
      end else if (pending) begin
        wait_cnt++;
        if (wait_cnt > 100) begin
          chk("accept_timeout", 32'(wait_cnt), 32'd100);
          pending = 1'b0;
        end
      end

      @(posedge sys_clk);
      #1;
      if ((rst_at != 0 && cyc == rst_at) ||
          (cyc < CYCLES && dir_q.size() == 0 && $urandom_range(0, 99) == 0)) begin
        sys_rst       = 1'b1;
        bus.req_valid = 1'b0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].cyc > cyc) exp_q.delete(i);
        ready_from = cyc + 1;
        rst_at     = 0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
      end
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bank_command_sequencer.md
BANK_COMMAND_SEQUENCER -- requirements
Module: bank_command_sequencer

Interface
REQ-001 Parameter T_RP, default 3, precharge-to-activate delay in cycles; legal range 2..15.
REQ-002 Parameter T_RCD, default 3, activate-to-access delay in cycles; legal range 2..15.
REQ-003 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_row  input  16  requested row address.
REQ-008 req_col  input  10  requested column address.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 row_open  input  1  row-buffer tracker: a row is open.
REQ-011 row_hit  input  1  row-buffer tracker: the open row equals requested_row.
REQ-012 requested_row  output  16  latched row, driven to the row-buffer tracker.
REQ-013 row_activate  output  1  one-cycle pulse telling the tracker to open requested_row.
REQ-014 row_precharge  output  1  one-cycle pulse telling the tracker to close the row.
REQ-015 cmd_valid  output  1  command issued this cycle.
REQ-016 cmd_type  output  2  0 = ACT, 1 = PRE, 2 = RD, 3 = WR; 0 when cmd_valid = 0.
REQ-017 cmd_row  output  16  row for ACT; 0 otherwise.
REQ-018 cmd_col  output  10  column for RD/WR; 0 otherwise.
REQ-019 done  output  1  one-cycle pulse in the RD/WR issue cycle.

Function
REQ-020 States SHALL be IDLE, CHECK, PRECHARGE, WAIT_RP, ACTIVATE, WAIT_RCD, ACCESS.
REQ-021 req_ready SHALL be 1 only in IDLE; the handshake req_valid & req_ready latches req_row, req_col and req_we, then moves to CHECK.
REQ-022 req_valid outside IDLE SHALL be ignored; latched fields hold until the next accepted request.
REQ-023 requested_row SHALL equal the latched row, valid from the cycle after acceptance.
REQ-024 CHECK: row_hit = 1 moves to ACCESS; else row_open = 1 moves to PRECHARGE; else ACTIVATE. row_hit and row_open SHALL be sampled only in CHECK.
REQ-025 PRECHARGE (1 cycle): cmd_valid = 1, cmd_type = PRE, row_precharge = 1; the 4-bit counter loads T_RP-2; next state WAIT_RP.
REQ-026 WAIT_RP: counter decrements each cycle; at 0, exits to ACTIVATE, so ACT occurs exactly T_RP cycles after PRE.
REQ-027 ACTIVATE (1 cycle): cmd_valid = 1, cmd_type = ACT, cmd_row = latched row, row_activate = 1; counter loads T_RCD-2; next state WAIT_RCD.
REQ-028 WAIT_RCD: as in REQ-026 with T_RCD; exits to ACCESS, so RD/WR occurs exactly T_RCD cycles after ACT.
REQ-029 ACCESS (1 cycle): cmd_valid = 1, cmd_type = WR if latched we else RD, cmd_col = latched col, done = 1; next state IDLE (see REQ-036).
REQ-030 Latency from the acceptance cycle (cycle 0): hit, RD/WR at cycle 2; closed-row miss, ACT at 2 and RD/WR at 2+T_RCD; open-row miss, PRE at 2, ACT at 2+T_RP and RD/WR at 2+T_RP+T_RCD.
REQ-031 At most one command SHALL be issued per cycle; row_activate and row_precharge are never asserted together.
REQ-032 After ACCESS the next request SHALL be acceptable in the following cycle (back-to-back requests: one idle cycle between commands).

Reset
REQ-033 sys_rst SHALL force IDLE, counter 0, latched row/col/we 0, requested_row 0 and all command and pulse outputs 0 in the following cycle; reset dominates all other inputs.
REQ-034 Reset in any state, including mid-wait, SHALL abort the request without issuing its remaining commands; req_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro BANK_SEQ_AUTO_PRECHARGE_EN selects the close-page policy.
REQ-036 With it defined: ACCESS proceeds to PRECHARGE (PRE issued one cycle after RD/WR), then WAIT_RP for T_RP cycles, then IDLE; req_ready stays 0 throughout; done still pulses in ACCESS.
REQ-037 Without it: open-page policy; ACCESS returns directly to IDLE and the row stays open.

Verification
REQ-038 T_RP = 3, T_RCD = 2, macro off; row_open = 0, read of row 0x0012 col 0x005 accepted at cycle 0 -> ACT row 0x0012 at cycle 2, RD col 0x005 plus done at cycle 4.
REQ-039 Same parameters; row_open = 1, row_hit = 1, write of col 0x3FF -> WR at cycle 2, no ACT or PRE.
REQ-040 Same parameters; row_open = 1, row_hit = 0, read of row 0xBEEF -> PRE at cycle 2, ACT 0xBEEF at cycle 5, RD at cycle 7.
REQ-041 sys_rst asserted during WAIT_RP -> no ACT ever issued; all outputs 0 next cycle; req_ready = 1 after deassertion.
REQ-042 req_valid held high during a miss sequence -> exactly one request accepted; the second is accepted the cycle after done.
REQ-043 Macro on, hit write at cycle 0 -> WR at cycle 2, PRE at cycle 3, req_ready = 1 at cycle 6.
